// File: rtl/led_matrix_pkg.sv
// Shared types and sizing helpers for the HUB75 LED-matrix scan engine.
package led_matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  // Channel index within a {R,G,B} pixel word, B in the low field
  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } chan_e;

  localparam int unsigned PX_MAX_W = 24;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned row_w(input int unsigned rows);
    return clog2_min1(rows / 2);
  endfunction

  function automatic int unsigned addr_w(input int unsigned rows, input int unsigned cols);
    return 1 + $clog2(rows) + $clog2(cols);
  endfunction

  // One bit-plane bit of one channel from a packed {R,G,B} pixel
  function automatic logic px_bit(input logic [PX_MAX_W-1:0] px, input chan_e ch,
                                  input int unsigned bpp, input int unsigned plane);
    logic [4:0] idx;
    idx = 5'(32'(ch) * bpp + plane);
    return px[idx];
  endfunction

endpackage

// File: rtl/led_col_shifter.sv
// Column shifter: walks COLS columns, issues framebuffer reads and drives sclk
// plus the six colour bits of the selected bit-plane.
module led_col_shifter
  import led_matrix_pkg::*;
#(
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 32,
  parameter int unsigned BPP     = 4,
  parameter int unsigned CLK_DIV = 2,
  localparam int unsigned AW     = addr_w(ROWS, COLS),
  localparam int unsigned RW     = row_w(ROWS),
  localparam int unsigned PW     = clog2_min1(BPP),
  localparam int unsigned PXW    = 3 * BPP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          buf_sel,
  input  logic [RW-1:0] row,
  input  logic [PW-1:0] plane,
  input  logic [PXW-1:0] fb_rdata_t,
  input  logic [PXW-1:0] fb_rdata_b,
  output logic [AW-1:0] fb_addr_t,
  output logic [AW-1:0] fb_addr_b,
  output logic          r0,
  output logic          g0,
  output logic          b0,
  output logic          r1,
  output logic          g1,
  output logic          b1,
  output logic          sclk,
  output logic          done_c
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned PHW = clog2_min1(2 * CLK_DIV);

  logic           active_q, active_nxt;
  logic [CW-1:0]  col_q, col_nxt;
  logic [PHW-1:0] ph_q, ph_nxt;
  logic           col_end_c;
  logic           sel_q;
  logic [RW-1:0]  row_q;
  logic [PW-1:0]  plane_q;

  // Column/phase sequencing; start always restarts at column 0, phase 0
  always_comb begin
    active_nxt = active_q;
    col_nxt    = col_q;
    ph_nxt     = ph_q;
    col_end_c  = active_q && (ph_q == PHW'(2 * CLK_DIV - 1));
    done_c     = col_end_c && (col_q == CW'(COLS - 1));
    if (start) begin
      active_nxt = 1'b1;
      col_nxt    = '0;
      ph_nxt     = '0;
    end else if (active_q) begin
      if (col_end_c) begin
        ph_nxt  = '0;
        col_nxt = col_q + CW'(1);
        if (done_c) active_nxt = 1'b0;
      end else begin
        ph_nxt = ph_q + PHW'(1);
      end
    end
  end

  // Address for column x is visible in its phase 0; read data lands in phase 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      col_q     <= '0;
      ph_q      <= '0;
      sel_q     <= 1'b0;
      row_q     <= '0;
      plane_q   <= '0;
      fb_addr_t <= '0;
      fb_addr_b <= '0;
      sclk      <= 1'b0;
      r0        <= 1'b0;
      g0        <= 1'b0;
      b0        <= 1'b0;
      r1        <= 1'b0;
      g1        <= 1'b0;
      b1        <= 1'b0;
    end else begin
      active_q <= active_nxt;
      col_q    <= col_nxt;
      ph_q     <= ph_nxt;
      sclk     <= active_nxt && (ph_nxt >= PHW'(CLK_DIV));
      if (start) begin
        sel_q     <= buf_sel;
        row_q     <= row;
        plane_q   <= plane;
        fb_addr_t <= {buf_sel, 1'b0, row, {CW{1'b0}}};
        fb_addr_b <= {buf_sel, 1'b1, row, {CW{1'b0}}};
      end else if (col_end_c && !done_c) begin
        fb_addr_t <= {sel_q, 1'b0, row_q, col_nxt};
        fb_addr_b <= {sel_q, 1'b1, row_q, col_nxt};
      end
      if (active_q && (ph_q == PHW'(1))) begin
        r0 <= px_bit(PX_MAX_W'(fb_rdata_t), CH_R, BPP, 32'(plane_q));
        g0 <= px_bit(PX_MAX_W'(fb_rdata_t), CH_G, BPP, 32'(plane_q));
        b0 <= px_bit(PX_MAX_W'(fb_rdata_t), CH_B, BPP, 32'(plane_q));
        r1 <= px_bit(PX_MAX_W'(fb_rdata_b), CH_R, BPP, 32'(plane_q));
        g1 <= px_bit(PX_MAX_W'(fb_rdata_b), CH_G, BPP, 32'(plane_q));
        b1 <= px_bit(PX_MAX_W'(fb_rdata_b), CH_B, BPP, 32'(plane_q));
      end
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// HUB75 scan engine: scan FSM, BCM display timer, row/plane counters and
// front/back framebuffer swap at frame boundaries.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned COLS       = 32,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned BPP        = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned BLANK_CYC  = 4,
  parameter int unsigned LSB_ON_CYC = 16,
  localparam int unsigned AW        = addr_w(ROWS, COLS),
  localparam int unsigned RW        = row_w(ROWS),
  localparam int unsigned PXW       = 3 * BPP
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           swap_req,
  output logic           swap_ack,
  output logic           fb_sel,
  output logic [AW-1:0]  fb_addr_t,
  output logic [AW-1:0]  fb_addr_b,
  input  logic [PXW-1:0] fb_rdata_t,
  input  logic [PXW-1:0] fb_rdata_b,
  output logic           r0,
  output logic           g0,
  output logic           b0,
  output logic           r1,
  output logic           g1,
  output logic           b1,
  output logic [RW-1:0]  row_addr,
  output logic           sclk,
  output logic           latch,
  output logic           oe_n,
  output logic           frame_done
);

  localparam int unsigned PW       = clog2_min1(BPP);
  localparam int unsigned DISP_MAX = LSB_ON_CYC << (BPP - 1);
  localparam int unsigned TMAX     = (DISP_MAX > BLANK_CYC) ? DISP_MAX : BLANK_CYC;
  localparam int unsigned TW       = clog2_min1(TMAX + 1);

  scan_state_e   state_q, state_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic [RW-1:0] row_q, row_nxt;
  logic [PW-1:0] plane_q, plane_nxt;
  logic          swap_pend_q;
  logic          swap_take_c;
  logic          fb_sel_nxt_c;
  logic          start_c;
  logic          shift_done_c;
  logic          timer_done_c;
  logic          last_plane_c;
  logic          last_row_c;
  logic          frame_done_nxt_c;

  // Next state, counters, and the swap decision taken on the frame_done cycle
  always_comb begin
    state_nxt        = state_q;
    timer_nxt        = timer_q;
    row_nxt          = row_q;
    plane_nxt        = plane_q;
    start_c          = 1'b0;
    timer_done_c     = (timer_q == '0);
    last_plane_c     = (plane_q == PW'(BPP - 1));
    last_row_c       = (row_q == RW'(ROWS / 2 - 1));
    swap_take_c      = frame_done && (swap_pend_q || swap_req);
    fb_sel_nxt_c     = fb_sel ^ swap_take_c;
    unique case (state_q)
      ST_IDLE: begin
        row_nxt   = '0;
        plane_nxt = '0;
        if (enable) begin
          state_nxt = ST_SHIFT;
          start_c   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_done_c) begin
          state_nxt = ST_BLANK;
          timer_nxt = TW'(BLANK_CYC - 1);
        end
      end
      ST_BLANK: begin
        if (timer_done_c) state_nxt = ST_LATCH;
        else              timer_nxt = timer_q - TW'(1);
      end
      ST_LATCH: begin
        state_nxt = ST_DISPLAY;
        timer_nxt = (TW'(LSB_ON_CYC) << plane_q) - TW'(1);
      end
      ST_DISPLAY: begin
        if (!timer_done_c) begin
          timer_nxt = timer_q - TW'(1);
        end else begin
          if (last_plane_c) begin
            plane_nxt = '0;
            row_nxt   = last_row_c ? '0 : row_q + RW'(1);
          end else begin
            plane_nxt = plane_q + PW'(1);
          end
          if (enable) begin
            state_nxt = ST_SHIFT;
            start_c   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            row_nxt   = '0;
            plane_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    frame_done_nxt_c = (state_nxt == ST_DISPLAY) && (timer_nxt == '0) &&
                       last_plane_c && last_row_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      swap_pend_q <= 1'b0;
      fb_sel      <= 1'b0;
      swap_ack    <= 1'b0;
      row_addr    <= '0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      timer_q     <= timer_nxt;
      row_q       <= row_nxt;
      plane_q     <= plane_nxt;
      swap_pend_q <= swap_take_c ? 1'b0 : (swap_pend_q || swap_req);
      fb_sel      <= fb_sel_nxt_c;
      swap_ack    <= swap_take_c;
      if ((state_q == ST_SHIFT) && (state_nxt == ST_BLANK)) row_addr <= row_q;
      latch       <= (state_nxt == ST_LATCH);
      oe_n        <= (state_nxt != ST_DISPLAY);
      frame_done  <= frame_done_nxt_c;
    end
  end

  // Shifter is handed the post-update row/plane/buffer so the first address is ready in SHIFT
  led_col_shifter #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .BPP     (BPP),
    .CLK_DIV (CLK_DIV)
  ) u_col_shifter (
    .clk        (clk),
    .reset      (reset),
    .start      (start_c),
    .buf_sel    (fb_sel_nxt_c),
    .row        (row_nxt),
    .plane      (plane_nxt),
    .fb_rdata_t (fb_rdata_t),
    .fb_rdata_b (fb_rdata_b),
    .fb_addr_t  (fb_addr_t),
    .fb_addr_b  (fb_addr_b),
    .r0         (r0),
    .g0         (g0),
    .b0         (b0),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .sclk       (sclk),
    .done_c     (shift_done_c)
  );

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: scan-line scoreboard against a framebuffer model.
module tb_led_matrix_scan;

  localparam int unsigned COLS = 4, ROWS = 4, BPP = 2, CLK_DIV = 2, BLANK_CYC = 2, LSB_ON_CYC = 4;
  localparam int unsigned AW = 5, RW = 1, PXW = 6, LINE_W = 6 * COLS;

  function automatic int unsigned frame_cycles();
    int unsigned s = 0;
    for (int p = 0; p < int'(BPP); p++) s += 2 * CLK_DIV * COLS + BLANK_CYC + 1 + (LSB_ON_CYC << p);
    return (ROWS / 2) * s;
  endfunction

  localparam int unsigned FRAME_CYC = frame_cycles();

  logic clk = 1'b0;
  logic reset, enable, swap_req;
  logic swap_ack, fb_sel, r0, g0, b0, r1, g1, b1, sclk, latch, oe_n, frame_done;
  logic [AW-1:0] fb_addr_t, fb_addr_b;
  logic [PXW-1:0] fb_rdata_t, fb_rdata_b;
  logic [RW-1:0] row_addr;
  logic [PXW-1:0] mem [0:31];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Framebuffer RAM with one cycle of read latency
  always @(posedge clk) begin
    fb_rdata_t <= mem[fb_addr_t];
    fb_rdata_b <= mem[fb_addr_b];
  end

  led_matrix_scan #(
    .COLS(COLS), .ROWS(ROWS), .BPP(BPP), .CLK_DIV(CLK_DIV),
    .BLANK_CYC(BLANK_CYC), .LSB_ON_CYC(LSB_ON_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req), .swap_ack(swap_ack),
    .fb_sel(fb_sel), .fb_addr_t(fb_addr_t), .fb_addr_b(fb_addr_b),
    .fb_rdata_t(fb_rdata_t), .fb_rdata_b(fb_rdata_b),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .row_addr(row_addr), .sclk(sclk), .latch(latch), .oe_n(oe_n), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected shifted bits for one scan line, column 0 first, {r0,g0,b0,r1,g1,b1} per column
  function automatic logic [LINE_W-1:0] exp_line(input int sel, input int row, input int plane);
    logic [LINE_W-1:0] v;
    logic [PXW-1:0] pt, pb;
    logic [4:0] at, ab;
    v = '0;
    for (int x = 0; x < int'(COLS); x++) begin
      at = 5'(sel * ROWS * COLS + row * COLS + x);
      ab = 5'(sel * ROWS * COLS + (row + ROWS / 2) * COLS + x);
      pt = mem[at];
      pb = mem[ab];
      v = {v[LINE_W-7:0], pt[2*BPP+plane], pt[BPP+plane], pt[plane],
                          pb[2*BPP+plane], pb[BPP+plane], pb[plane]};
    end
    return v;
  endfunction

  // Scoreboard state
  int m_row, m_plane, run, fd_pos, nrise, cyc, last_fd;
  bit m_sel, pend, ack_exp, take, fd_valid, sclk_q, latch_q, en_q, first_line;
  logic [LINE_W-1:0] line_bits;
  logic [3:0] r0_seq;

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_sel = 0; pend = 0; ack_exp = 0; m_row = 0; m_plane = 0; run = 0; fd_pos = 0;
        nrise = 0; line_bits = '0; fd_valid = 0; sclk_q = 0; latch_q = 0; en_q = 0;
        first_line = 1;
      end else begin
        cyc++;
        check("oe_overlap", 32'(!oe_n && (latch || sclk)), 32'(0));
        check("swap_ack", 32'(swap_ack), 32'(ack_exp));
        check("fb_sel", 32'(fb_sel), 32'(m_sel));
        take = frame_done && (pend || swap_req);
        ack_exp = take;
        if (take) m_sel = !m_sel;
        pend = take ? 1'b0 : (pend || swap_req);
        if (sclk && !sclk_q) begin
          line_bits = {line_bits[LINE_W-7:0], r0, g0, b0, r1, g1, b1};
          nrise++;
        end
        if (latch && !latch_q) begin
          check("sclk_rises", 32'(nrise), 32'(COLS));
          check("row_addr", 32'(row_addr), 32'(m_row));
          check("line_data", 32'(line_bits), 32'(exp_line(int'(m_sel), m_row, m_plane)));
          if (first_line) begin
            for (int c = 0; c < 4; c++) r0_seq[3-c] = line_bits[LINE_W-1-6*c];
            check("first_r0_seq", 32'(r0_seq), 32'(4'b0101));
            first_line = 0;
          end
          nrise = 0;
          line_bits = '0;
        end
        if (frame_done) begin
          check("fd_while_oe", 32'(oe_n), 32'(0));
          if (fd_valid) check("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYC));
          last_fd = cyc;
          fd_valid = 1;
        end
        if (!oe_n) begin
          run++;
          if (frame_done) fd_pos = run;
        end else if (run > 0) begin
          check("disp_len", 32'(run), 32'(LSB_ON_CYC << m_plane));
          check("frame_done_pos", 32'(fd_pos),
                32'((m_row == ROWS / 2 - 1 && m_plane == BPP - 1) ? run : 0));
          if (!en_q) begin
            m_row = 0; m_plane = 0; fd_valid = 0;
          end else if (m_plane == BPP - 1) begin
            m_plane = 0; m_row = (m_row + 1) % (ROWS / 2);
          end else begin
            m_plane++;
          end
          run = 0;
          fd_pos = 0;
        end
        sclk_q = sclk;
        latch_q = latch;
        en_q = enable;
      end
    end
  end

  // Bounded wait: 0 = frame_done, 1 = sclk high, 2 = oe_n low; returns 1ns after the hit edge
  task automatic wait_for(input string tag, input int sig, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      case (sig)
        0: hit = frame_done;
        1: hit = sclk;
        default: hit = !oe_n;
      endcase
    end
    check(tag, 32'(hit), 32'(1));
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; swap_req = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = {2'(a % 4), 2'(a / 4), 2'b11};
    for (int a = 16; a < 32; a++) mem[a] = 6'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n", 32'(oe_n), 32'(1));
    check("rst_outs", 32'({swap_ack, fb_sel, r0, g0, b0, r1, g1, b1, row_addr, sclk, latch, frame_done}), 32'(0));
    check("rst_addr", 32'({fb_addr_t, fb_addr_b}), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;

    // Swap request early in the first frame takes effect right after its frame_done
    repeat (29) @(posedge clk);
    #1 pulse_swap();
    wait_for("tmo_fd1", 0, 150);
    @(posedge clk); #1;
    check("swap1_sel", 32'(fb_sel), 32'(1));
    check("swap1_ack", 32'(swap_ack), 32'(1));
    check("swap1_addr_msb", 32'({fb_addr_t[AW-1], fb_addr_b[AW-1]}), 32'(2'b11));

    // Request coincident with frame_done
    wait_for("tmo_fd2", 0, 150);
    pulse_swap();
    // Two requests inside one frame coalesce
    repeat (10) @(posedge clk);
    #1 pulse_swap();
    repeat (30) @(posedge clk);
    #1 pulse_swap();
    repeat (150) @(posedge clk);

    // Random request traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      swap_req = ($urandom_range(29) == 0);
    end
    @(posedge clk); #1 swap_req = 1'b0;

    // Drop enable mid-SHIFT: finish the plane, then idle with the panel dark
    wait_for("tmo_shift", 1, 200);
    enable = 1'b0;
    repeat (60) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_dark", 32'({oe_n, sclk, latch}), 32'(3'b100));
    end
    enable = 1'b1;
    repeat (250) @(posedge clk);

    // Async reset during DISPLAY
    wait_for("tmo_disp", 2, 200);
    #2 reset = 1'b1;
    #1;
    check("areset_outs", 32'({oe_n, latch, sclk, fb_sel, frame_done}), 32'(5'b10000));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
